// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the cpu_div_cell restoring divider.
// Holds the FSM state type, the divide-by-zero quotient pattern and the CALC length.
package cpu_div_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  localparam int DIV_DEFAULT_W = 32;
  // One quotient bit per CALC cycle, so CALC lasts exactly DATA_W cycles.
  localparam int DIV_CALC_LEN  = DIV_DEFAULT_W;
  localparam int DIV_MAX_W     = 64;

  // All-ones quotient reported on divide-by-zero; valid for widths up to DIV_MAX_W.
  function automatic logic [DIV_MAX_W-1:0] div_dz_quot(input int w);
    return {DIV_MAX_W{1'b1}} >> (DIV_MAX_W - w);
  endfunction

endpackage

// File: rtl/cpu_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module cpu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_msb_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem_i < divisor, so both candidate results fit back into DATA_W bits.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = ~diff[DATA_W];
    rem_o   = q_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/cpu_div_cell.sv
// Sequential radix-2 signed/unsigned divider, one quotient bit per clock.
// Optional build macro CPU_DIV_ZERO_SHORTCUT_EN: divisor==0 skips CALC entirely.
module cpu_div_cell
  import cpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DEFAULT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_signed,
  input  logic              E_start,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quot,
  output logic [DATA_W-1:0] M_div_rem,
  output logic              M_div_dz
);

  localparam int                CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] DZ_QUOT  = DATA_W'(div_dz_quot(DATA_W));

  div_state_t        state_q, state_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic              signed_q, signed_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] prem_q, prem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              dz_q, dz_d;

  logic              sign1;
  logic              sign2;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;

  cpu_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (prem_q),
    .dvd_msb_i (dvd_q[DATA_W-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d    = state_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    signed_d   = signed_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    sign1      = signed_q & src1_q[DATA_W-1];
    sign2      = signed_q & src2_q[DATA_W-1];

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (E_start) begin
          state_d  = DIV_PREP;
          src1_d   = E_src1;
          src2_d   = E_src2;
          signed_d = E_div_signed;
        end
      end
      DIV_PREP: begin
        dvd_d      = sign1 ? -src1_q : src1_q;
        dvs_d      = sign2 ? -src2_q : src2_q;
        neg_quot_d = sign1 ^ sign2;
        neg_rem_d  = sign1;
        prem_d     = '0;
        cnt_d      = CNT_LOAD;
        dz_d       = 1'b0;
        state_d    = DIV_CALC;
`ifdef CPU_DIV_ZERO_SHORTCUT_EN
        if (src2_q == '0) begin
          state_d = DIV_FIX;
        end
`endif
      end
      DIV_CALC: begin
        // Quotient bits shift into the vacated low end of the dividend register.
        prem_d = step_rem;
        dvd_d  = {dvd_q[DATA_W-2:0], step_q};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        if (src2_q == '0) begin
          quot_d = DZ_QUOT;
          rem_d  = src1_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = neg_quot_q ? -dvd_q : dvd_q;
          rem_d  = neg_rem_q ? -prem_q : prem_q;
        end
        state_d = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= DIV_IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      signed_q   <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      signed_q   <= signed_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      prem_q     <= prem_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
    end
  end

  // Handshake outputs decode the state register only, so no input reaches an output.
  assign M_div_busy = (state_q == DIV_PREP) || (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign M_div_done = (state_q == DIV_DONE);
  assign M_div_quot = quot_q;
  assign M_div_rem  = rem_q;
  assign M_div_dz   = dz_q;

endmodule

// File: doc/cpu_div_cell.md
# cpu_div_cell

Sequential radix-2 restoring integer divider for the CPU datapath: the inverse-operation companion to the multiplier cell, taking operands from the E stage and returning quotient and remainder to the M stage. One quotient bit per clock; a start/busy/done handshake lets the pipeline stall while the divide runs. It supports both signed and unsigned operation, with fixed divide-by-zero and overflow semantics.

## Interface
Parameters:
- DATA_W, 32, operand/result width; latency scales with it.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- E_src1  in  DATA_W  dividend.
- E_src2  in  DATA_W  divisor.
- E_div_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- E_start  in  1  request; sampled only when M_div_busy=0.
- M_div_busy  out  1  high from the cycle after start acceptance until DONE.
- M_div_done  out  1  one-cycle pulse; results valid from this cycle.
- M_div_quot  out  DATA_W  quotient, truncated toward zero.
- M_div_rem  out  DATA_W  remainder; sign follows dividend.
- M_div_dz  out  1  divisor was zero; valid with done, held.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE/DONE: busy=0. E_start=1 latches operands and signed flag, then goes to PREP.
- PREP (1 cycle):
  - signed: take magnitudes of both operands; record neg_q = sign1^sign2 and neg_r = sign1.
  - Clear partial remainder; load the iteration counter with DATA_W-1.
- CALC (DATA_W cycles), each cycle:
  - rem' = {rem, dvd_msb}; shift dividend left.
  - If rem' >= divisor: rem = rem' - divisor and q bit = 1; else rem = rem' and q bit = 0.
  - The subtract is DATA_W+1 bits wide.
  - Counter at 0 moves to FIX.
- FIX (1 cycle):
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Skip negation when the divisor is zero.
  - Register the outputs.
- DONE (1 cycle): done=1, then IDLE. E_start=1 here starts a new divide (back-to-back).
- Divide by zero (either mode): quot = all-ones, rem = dividend unmodified, dz=1.
- Signed overflow: 0x80000000 / -1 gives quot=0x80000000, rem=0. This falls out of the unsigned-magnitude path and needs no special case.
- E_start while busy=1 is ignored; no queuing.
- Outputs hold their last result until the next FIX. dz is cleared at PREP.
- Reset (any state, including mid-CALC): state=IDLE and all outputs 0 (busy=0, done=0, quot=0, rem=0, dz=0). An aborted divide never produces done.

## Timing
- Start sampled at edge T0. PREP occupies cycle T0+1. CALC occupies T0+2..T0+DATA_W+1. FIX occupies T0+DATA_W+2.
- done is high in cycle T0+DATA_W+3 (cycle 35 for DATA_W=32).
- busy is high from T0+1 through T0+DATA_W+2.
- No combinational path from any input to any output.

## Configuration
- CPU_DIV_ZERO_SHORTCUT_EN defined:
  - PREP detects divisor==0 and jumps directly to FIX, skipping CALC.
  - done arrives at T0+3.
- Undefined:
  - The divisor-zero case runs the full CALC, which naturally yields all-ones / dividend.
  - done arrives at T0+DATA_W+3.
- Results and dz are identical in both builds; only latency differs.

## Structure
- Package cpu_div_pkg holds:
  - the state enum type div_state_t;
  - the DIV_DZ_QUOT all-ones constant (width-parameterized function);
  - the CALC-length localparam.
- Sub-module cpu_div_step: one combinational restoring iteration.
  - Inputs: rem, dividend msb, divisor.
  - Outputs: next rem, q bit.
  - Instantiated once, used every CALC cycle.

## Test plan
- Unsigned 100 / 7, start at T0: done at T0+35, quot=14, rem=2, dz=0; busy high T0+1..T0+34.
- Signed -7 / 2 (0xFFFFFFF9 / 2): quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7 / -2: quot=0xFFFFFFFD, rem=1.
- Signed 0x80000000 / 0xFFFFFFFF: quot=0x80000000, rem=0, dz=0. The same operands unsigned give quot=0, rem=0x80000000.
- 0x1234 / 0 (signed and unsigned): quot=0xFFFFFFFF, rem=0x1234, dz=1. done at T0+3 with CPU_DIV_ZERO_SHORTCUT_EN, at T0+35 without.
- E_start pulsed at T0+5 during busy: ignored, result unchanged. reset_n low at T0+10: next edge gives busy=0 and all outputs 0, and no done ever follows.
- Back-to-back: new start asserted in the DONE cycle of 100/7. The second op 50/5 gives done exactly 35 cycles later with quot=10, rem=0.
